// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-requester SRAM arbiter.
// Holds the requester ID, the fixed requester roles and the outstanding-read counter width.
package sram_arb_pkg;

  typedef logic req_id_t;

  localparam req_id_t REQ_CPU  = 1'b0;
  localparam req_id_t REQ_DISP = 1'b1;

  function automatic int pend_cnt_w(input int max_pend);
    return $clog2(max_pend) + 1;
  endfunction

endpackage

// File: rtl/sram_arb_if.sv
// One Avalon-MM requester port: a pipelined read/write command with a
// same-cycle waitrequest, plus a read-return strobe.
interface sram_arb_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int BE_W   = 2
);

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/sram_arb_tag_fifo.sv
// Small synchronous FIFO holding the requester ID of every outstanding read.
// A push is dropped when full and a pop is dropped when empty; the head is readable combinationally.
module sram_arb_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [W-1:0]     head
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one pipelined Avalon SRAM slave between two requesters.
// Grant and waitrequest are same-cycle; the command is registered (1 cycle); reads stall when the tag FIFO is full.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16,
  parameter int BE_W     = 2,
  parameter int MAX_PEND = 4
) (
  input  logic                              clk_clk,
  input  logic                              reset_reset_n,
  sram_arb_if.slave                         m0,
  sram_arb_if.slave                         m1,
  output logic [ADDR_W-1:0]                 s_address,
  output logic [BE_W-1:0]                   s_byteenable,
  output logic                              s_read,
  output logic                              s_write,
  output logic [DATA_W-1:0]                 s_writedata,
  input  logic [DATA_W-1:0]                 s_readdata,
  input  logic                              s_readdatavalid,
  output logic [pend_cnt_w(MAX_PEND)-1:0]   pend_count,
  output logic                              err_orphan
);

  logic        full;
  logic        empty;
  req_id_t     head;
  req_id_t     last_grant;
  logic        elig0, elig1;
  logic        grant0, grant1;
  logic        push, pop;
  logic        rdv0, rdv1;
  logic [DATA_W-1:0] rd0_q, rd1_q;

  // Read+write together is a read, so the read strobe alone decides eligibility.
  assign elig0 = m0.read ? ~full : m0.write;
  assign elig1 = m1.read ? ~full : m1.write;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (elig0 && elig1) begin
      grant0 = (last_grant != REQ_CPU);
      grant1 = (last_grant == REQ_CPU);
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  assign m0.waitrequest = (m0.read | m0.write) & ~grant0;
  assign m1.waitrequest = (m1.read | m1.write) & ~grant1;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      s_address    <= '0;
      s_byteenable <= '0;
      s_read       <= 1'b0;
      s_write      <= 1'b0;
      s_writedata  <= '0;
      last_grant   <= REQ_DISP;
    end else begin
      s_read  <= 1'b0;
      s_write <= 1'b0;
      if (grant0) begin
        s_address    <= m0.address;
        s_byteenable <= m0.byteenable;
        s_writedata  <= m0.writedata;
        s_read       <= m0.read;
        s_write      <= m0.write & ~m0.read;
        last_grant   <= REQ_CPU;
      end else if (grant1) begin
        s_address    <= m1.address;
        s_byteenable <= m1.byteenable;
        s_writedata  <= m1.writedata;
        s_read       <= m1.read;
        s_write      <= m1.write & ~m1.read;
        last_grant   <= REQ_DISP;
      end
    end
  end

  assign push = (grant0 & m0.read) | (grant1 & m1.read);
  assign pop  = s_readdatavalid & ~empty;

  sram_arb_tag_fifo #(
    .DEPTH (MAX_PEND),
    .W     (1)
  ) u_tag_fifo (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .push     (push),
    .push_dat (grant1 ? REQ_DISP : REQ_CPU),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .count    (pend_count),
    .head     (head)
  );

  assign rdv0 = pop & (head == REQ_CPU);
  assign rdv1 = pop & (head == REQ_DISP);

  assign m0.readdatavalid = rdv0;
  assign m1.readdatavalid = rdv1;
  assign m0.readdata      = rdv0 ? s_readdata : rd0_q;
  assign m1.readdata      = rdv1 ? s_readdata : rd1_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rd0_q      <= '0;
      rd1_q      <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (rdv0) rd0_q <= s_readdata;
      if (rdv1) rd1_q <= s_readdata;
      if (s_readdatavalid && empty) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scenario bench for sram_arbiter: expected slave commands and read returns are queued
// as stimulus is driven and checked by monitors when the DUT produces them.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int ADDR_W   = 20;
  localparam int DATA_W   = 16;
  localparam int BE_W     = 2;
  localparam int MAX_PEND = 4;
  localparam int PC_W     = pend_cnt_w(MAX_PEND);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] s_address;
  logic [BE_W-1:0]   s_byteenable;
  logic              s_read;
  logic              s_write;
  logic [DATA_W-1:0] s_writedata;
  logic [DATA_W-1:0] s_readdata;
  logic              s_readdatavalid;
  logic [PC_W-1:0]   pend_count;
  logic              err_orphan;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } cmd_t;

  cmd_t              exp_cmd[$];
  logic [DATA_W-1:0] exp0[$];
  logic [DATA_W-1:0] exp1[$];

  sram_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m0_if ();
  sram_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m1_if ();

  sram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .MAX_PEND(MAX_PEND)
  ) dut (
    .clk_clk         (clk),
    .reset_reset_n   (rst_n),
    .m0              (m0_if),
    .m1              (m1_if),
    .s_address       (s_address),
    .s_byteenable    (s_byteenable),
    .s_read          (s_read),
    .s_write         (s_write),
    .s_writedata     (s_writedata),
    .s_readdata      (s_readdata),
    .s_readdatavalid (s_readdatavalid),
    .pend_count      (pend_count),
    .err_orphan      (err_orphan)
  );

  always #5 clk = ~clk;

  function automatic cmd_t mk_cmd(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                                  input logic [DATA_W-1:0] data, input logic [BE_W-1:0] be);
    cmd_t c;
    c.rd = rd; c.wr = wr; c.addr = addr; c.data = data; c.be = be;
    return c;
  endfunction

  // Slave-side command scoreboard
  always @(negedge clk) begin
    cmd_t e;
    if (rst_n && (s_read || s_write)) begin
      tests++;
      if (exp_cmd.size() == 0) begin
        fails++;
        $display("FAIL cmd_unexpected got rd=%0b wr=%0b addr=%h", s_read, s_write, s_address);
      end else begin
        e = exp_cmd.pop_front();
        if (s_read !== e.rd || s_write !== e.wr || s_address !== e.addr ||
            (e.wr && (s_writedata !== e.data || s_byteenable !== e.be))) begin
          fails++;
          $display("FAIL cmd_order got rd=%0b wr=%0b addr=%h data=%h be=%b exp rd=%0b wr=%0b addr=%h data=%h be=%b",
                   s_read, s_write, s_address, s_writedata, s_byteenable, e.rd, e.wr, e.addr, e.data, e.be);
        end
      end
    end
  end

  // Read-return scoreboards
  always @(negedge clk) begin
    logic [DATA_W-1:0] e;
    if (rst_n && m0_if.readdatavalid === 1'b1) begin
      tests++;
      if (exp0.size() == 0) begin
        fails++;
        $display("FAIL m0_return_unexpected got %h", m0_if.readdata);
      end else begin
        e = exp0.pop_front();
        if (m0_if.readdata !== e) begin
          fails++;
          $display("FAIL m0_return got %h exp %h", m0_if.readdata, e);
        end
      end
    end
    if (rst_n && m1_if.readdatavalid === 1'b1) begin
      tests++;
      if (exp1.size() == 0) begin
        fails++;
        $display("FAIL m1_return_unexpected got %h", m1_if.readdata);
      end else begin
        e = exp1.pop_front();
        if (m1_if.readdata !== e) begin
          fails++;
          $display("FAIL m1_return got %h exp %h", m1_if.readdata, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_if.address = '0; m0_if.byteenable = '0; m0_if.read = 1'b0; m0_if.write = 1'b0; m0_if.writedata = '0;
    m1_if.address = '0; m1_if.byteenable = '0; m1_if.read = 1'b0; m1_if.write = 1'b0; m1_if.writedata = '0;
    s_readdata = '0;
    s_readdatavalid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    #2;
    tests++;
    if ({s_read, s_write, s_address, s_byteenable, s_writedata} !== '0) begin
      fails++;
      $display("FAIL reset_s_bus got rd=%0b wr=%0b addr=%h data=%h", s_read, s_write, s_address, s_writedata);
    end
    tests++;
    if ({pend_count, err_orphan} !== '0) begin
      fails++;
      $display("FAIL reset_status got pend=%0d err=%0b exp 0 0", pend_count, err_orphan);
    end
    tests++;
    if ({m0_if.readdatavalid, m1_if.readdatavalid, m0_if.readdata, m1_if.readdata} !== '0) begin
      fails++;
      $display("FAIL reset_returns got rdv0=%0b rdv1=%0b rd0=%h rd1=%h", m0_if.readdatavalid,
               m1_if.readdatavalid, m0_if.readdata, m1_if.readdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    do_reset();
    m0_if.write = 1'b1; m0_if.address = 20'h00010; m0_if.writedata = 16'hBEEF; m0_if.byteenable = 2'b11;
    exp_cmd.push_back(mk_cmd(1'b0, 1'b1, 20'h00010, 16'hBEEF, 2'b11));
    #2;
    tests++;
    if (m0_if.waitrequest !== 1'b0) begin
      fails++;
      $display("FAIL write_wait got %b exp 0", m0_if.waitrequest);
    end
    step();
    m0_if.write = 1'b0;
    step();
    #2;
    tests++;
    if (s_write !== 1'b0 || s_address !== 20'h00010) begin
      fails++;
      $display("FAIL write_one_cycle got wr=%0b addr=%h exp wr=0 addr=00010", s_write, s_address);
    end
  endtask

  task automatic test_alternate();
    logic [PC_W-1:0] peak;
    peak = '0;
    do_reset();
    exp0.push_back(16'h1111); exp1.push_back(16'h2222);
    exp0.push_back(16'h3333); exp1.push_back(16'h4444);
    m0_if.address = 20'h00100;
    m1_if.address = 20'h00200;
    for (int i = 0; i < 6; i++) begin
      m0_if.read = (i < 4);
      m1_if.read = (i < 4);
      s_readdatavalid = (i >= 2);
      s_readdata = (i >= 2) ? 16'(16'h1111 * (i - 1)) : 16'h0;
      if (i < 4) exp_cmd.push_back(mk_cmd(1'b1, 1'b0, (i % 2 == 1) ? 20'h00200 : 20'h00100, 16'h0, 2'b0));
      #2;
      if (i < 4) begin
        tests++;
        if (m0_if.waitrequest !== (i % 2 == 1) || m1_if.waitrequest !== (i % 2 == 0)) begin
          fails++;
          $display("FAIL alt_grant cycle %0d got wait0=%b wait1=%b", i, m0_if.waitrequest, m1_if.waitrequest);
        end
      end
      if (pend_count > peak) peak = pend_count;
      step();
    end
    s_readdatavalid = 1'b0;
    #2;
    tests++;
    if (peak !== PC_W'(2)) begin
      fails++;
      $display("FAIL alt_peak_pend got %0d exp 2", peak);
    end
    tests++;
    if (pend_count !== '0) begin
      fails++;
      $display("FAIL alt_drained got %0d exp 0", pend_count);
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    m1_if.address = 20'h00300;
    m0_if.address = 20'h00040; m0_if.writedata = 16'hCAFE; m0_if.byteenable = 2'b01;
    for (int i = 0; i < 12; i++) begin
      m1_if.read = (i <= 6);
      m0_if.write = (i == 4);
      s_readdatavalid = (i == 5) || (i >= 7 && i <= 10);
      s_readdata = 16'hA000 | 16'(i);
      if (i < 4 || i == 6) exp_cmd.push_back(mk_cmd(1'b1, 1'b0, 20'h00300, 16'h0, 2'b0));
      if (i == 4) exp_cmd.push_back(mk_cmd(1'b0, 1'b1, 20'h00040, 16'hCAFE, 2'b01));
      if (s_readdatavalid) exp1.push_back(16'hA000 | 16'(i));
      #2;
      if (i == 4) begin
        tests++;
        if (pend_count !== PC_W'(4) || m1_if.waitrequest !== 1'b1 || m0_if.waitrequest !== 1'b0) begin
          fails++;
          $display("FAIL full_stall got pend=%0d wait1=%b wait0=%b exp 4 1 0", pend_count,
                   m1_if.waitrequest, m0_if.waitrequest);
        end
      end
      if (i == 5) begin
        tests++;
        if (m1_if.waitrequest !== 1'b1) begin
          fails++;
          $display("FAIL full_pop_same_cycle got wait1=%b exp 1", m1_if.waitrequest);
        end
      end
      if (i == 6) begin
        tests++;
        if (m1_if.waitrequest !== 1'b0 || pend_count !== PC_W'(3)) begin
          fails++;
          $display("FAIL full_resume got wait1=%b pend=%0d exp 0 3", m1_if.waitrequest, pend_count);
        end
      end
      step();
    end
    s_readdatavalid = 1'b0;
    #2;
    tests++;
    if (pend_count !== '0) begin
      fails++;
      $display("FAIL full_drained got %0d exp 0", pend_count);
    end
  endtask

  task automatic test_orphan();
    do_reset();
    s_readdatavalid = 1'b1; s_readdata = 16'hDEAD;
    #2;
    tests++;
    if (m0_if.readdatavalid !== 1'b0 || m1_if.readdatavalid !== 1'b0) begin
      fails++;
      $display("FAIL orphan_strobe got rdv0=%b rdv1=%b exp 0 0", m0_if.readdatavalid, m1_if.readdatavalid);
    end
    step();
    s_readdatavalid = 1'b0;
    #2;
    tests++;
    if (err_orphan !== 1'b1) begin
      fails++;
      $display("FAIL orphan_flag got %b exp 1", err_orphan);
    end
    step();
    step();
    #2;
    tests++;
    if (err_orphan !== 1'b1) begin
      fails++;
      $display("FAIL orphan_sticky got %b exp 1", err_orphan);
    end
  endtask

  task automatic test_read_vs_write();
    do_reset();
    m0_if.read = 1'b1; m0_if.address = 20'h00500;
    m1_if.write = 1'b1; m1_if.address = 20'h00600; m1_if.writedata = 16'h1234; m1_if.byteenable = 2'b11;
    exp_cmd.push_back(mk_cmd(1'b1, 1'b0, 20'h00500, 16'h0, 2'b0));
    exp_cmd.push_back(mk_cmd(1'b0, 1'b1, 20'h00600, 16'h1234, 2'b11));
    #2;
    tests++;
    if (m0_if.waitrequest !== 1'b0 || m1_if.waitrequest !== 1'b1) begin
      fails++;
      $display("FAIL rw_first got wait0=%b wait1=%b exp 0 1", m0_if.waitrequest, m1_if.waitrequest);
    end
    step();
    m0_if.read = 1'b0;
    #2;
    tests++;
    if (m1_if.waitrequest !== 1'b0) begin
      fails++;
      $display("FAIL rw_second got wait1=%b exp 0", m1_if.waitrequest);
    end
    step();
    m1_if.write = 1'b0;
    s_readdatavalid = 1'b1; s_readdata = 16'h5A5A;
    exp0.push_back(16'h5A5A);
    #2;
    tests++;
    if (m1_if.readdatavalid !== 1'b0 || m1_if.readdata !== 16'h0) begin
      fails++;
      $display("FAIL rw_m1_quiet got rdv1=%b rd1=%h exp 0 0000", m1_if.readdatavalid, m1_if.readdata);
    end
    step();
    s_readdatavalid = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    m1_if.read = 1'b1; m1_if.address = 20'h00700;
    for (int i = 0; i < 3; i++) begin
      exp_cmd.push_back(mk_cmd(1'b1, 1'b0, 20'h00700, 16'h0, 2'b0));
      step();
    end
    m1_if.read = 1'b0;
    #2;
    tests++;
    if (pend_count !== PC_W'(3)) begin
      fails++;
      $display("FAIL arst_pend_before got %0d exp 3", pend_count);
    end
    #4;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({s_read, s_write, s_address, s_writedata, pend_count} !== '0) begin
      fails++;
      $display("FAIL arst_immediate got rd=%0b addr=%h pend=%0d exp 0", s_read, s_address, pend_count);
    end
    step();
    rst_n = 1'b1;
    s_readdatavalid = 1'b1; s_readdata = 16'h7777;
    step();
    s_readdatavalid = 1'b0;
    m0_if.read = 1'b1; m0_if.address = 20'h00800;
    m1_if.read = 1'b1; m1_if.address = 20'h00900;
    exp_cmd.push_back(mk_cmd(1'b1, 1'b0, 20'h00800, 16'h0, 2'b0));
    #2;
    tests++;
    if (err_orphan !== 1'b1) begin
      fails++;
      $display("FAIL arst_late_orphan got %b exp 1", err_orphan);
    end
    tests++;
    if (m0_if.waitrequest !== 1'b0 || m1_if.waitrequest !== 1'b1) begin
      fails++;
      $display("FAIL arst_m0_wins got wait0=%b wait1=%b exp 0 1", m0_if.waitrequest, m1_if.waitrequest);
    end
    step();
    m0_if.read = 1'b0;
    m1_if.read = 1'b0;
    step();
    s_readdatavalid = 1'b1; s_readdata = 16'h8888;
    exp0.push_back(16'h8888);
    step();
    s_readdatavalid = 1'b0;
    step();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_write();
    test_alternate();
    test_fifo_full();
    test_orphan();
    test_read_vs_write();
    test_async_reset();
    step();
    tests++;
    if (exp_cmd.size() != 0 || exp0.size() != 0 || exp1.size() != 0) begin
      fails++;
      $display("FAIL leftover_expected got cmd=%0d m0=%0d m1=%0d exp 0 0 0",
               exp_cmd.size(), exp0.size(), exp1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
